fetch_stage: RTL
================

# fetch_stage

Instruction-fetch (IF) stage of the 5-stage pipeline. It generates the sequential PC and issues one instruction-memory read at a time over a req/addr_ok/data_ok handshake. It presents {pc, inst} to the decode stage through the valid/allow_in pipeline handshake. It accepts redirects from decode's branch bus, and cancels or discards any wrong-path fetch that is in flight or buffered.

## Interface
- RESET_PC, 32'h1c000000, first fetch address after reset.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- br_data  input  33  {br_taken[32], br_target[31:0]} from decode.
  - br_taken is valid in the cycle it is asserted.
  - It is only asserted for a valid, non-stalled decode instruction.
- ID_allow_in  input  1  decode can accept an instruction this cycle.
- IF_to_ID_valid  output  1  to_ID_data holds a valid fetched instruction.
- to_ID_data  output  64  {pc[63:32], inst[31:0]}.
- inst_sram_req  output  1  read request.
- inst_sram_addr  output  32  read address; equals req_pc.
- inst_sram_addr_ok  input  1  request accepted this cycle.
- inst_sram_data_ok  input  1  read data returned this cycle.
  - Always at least 1 cycle after the corresponding addr_ok.
- inst_sram_rdata  input  32  instruction word, valid with data_ok.

## Operation
- Registers:
  - state ∈ {REQ, WAIT, VALID}.
  - req_pc[31:0]: next address to fetch.
  - out_pc[31:0] and out_inst[31:0]: the output buffer.
  - cancel: discard the next data_ok.
- Outputs:
  - inst_sram_req = (state==REQ) & ~reset.
  - IF_to_ID_valid = (state==VALID) & ~br_taken.
  - to_ID_data = {out_pc, out_inst}.
- REQ:
  - addr_ok & ~br_taken: go to WAIT; out_pc <= req_pc; req_pc <= req_pc + 4.
  - addr_ok & br_taken: go to WAIT; cancel <= 1; req_pc <= br_target.
  - ~addr_ok & br_taken: stay in REQ; req_pc <= br_target. The address may change while unaccepted.
- WAIT:
  - data_ok & ~cancel & ~br_taken: go to VALID; out_inst <= rdata.
  - data_ok & (cancel | br_taken): drop the data; cancel <= 0; go to REQ. If br_taken, req_pc <= br_target.
  - ~data_ok & br_taken: cancel <= 1; req_pc <= br_target; stay in WAIT.
- VALID:
  - br_taken (highest priority, even if ID_allow_in=1): buffer discarded; req_pc <= br_target; go to REQ.
  - ID_allow_in & ~br_taken: handoff completes; go to REQ.
  - Otherwise: hold. to_ID_data stays stable while stalled.
- Ignored inputs: data_ok in REQ or VALID (no outstanding read) and addr_ok outside REQ.
- Outstanding reads: at most one at any time.
- PC arithmetic: 32-bit, wraps modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000). The target is used as given; no alignment check.

## Timing
- Reset values:
  - state=REQ, req_pc=RESET_PC, out_pc=0, out_inst=0, cancel=0.
  - inst_sram_req=0 and IF_to_ID_valid=0 during reset.
- The first request is issued in the first cycle after reset deasserts.
- Reset mid-operation clears all state. A data_ok for a pre-reset request arriving in the first post-reset WAIT is not discarded by this block; the memory side must flush on reset.
- Best-case latency, with addr_ok in the request cycle and data_ok 1 cycle later:
  - Request cycle T.
  - IF_to_ID_valid at T+2.
  - Next request at T+3 if ID_allow_in=1 at T+2.
  - Sustained rate is 1 instruction per 3 cycles.
- Redirect: the first request to br_target is issued the cycle after br_taken, or the cycle after the discarded data_ok if a read was in flight.

## Test plan
- Reset, then memory with 1-cycle data_ok and ID_allow_in=1:
  - addresses 0x1c000000, 0x1c000004, 0x1c000008 are issued.
  - IF_to_ID_valid pulses with matching out_pc/inst every 3 cycles.
- ID_allow_in held 0 for 5 cycles in VALID:
  - IF_to_ID_valid stays 1 and to_ID_data is unchanged.
  - No new request is issued until allow_in=1.
- br_taken to 0x1c000100 in WAIT, with data_ok 2 cycles later:
  - the returned word is dropped and IF_to_ID_valid stays 0;
  - the next request address is 0x1c000100.
- br_taken coinciding with addr_ok for 0x1c000010: the data is discarded and the next request is to br_target.
- br_taken and ID_allow_in together in VALID:
  - IF_to_ID_valid=0 that cycle;
  - the next request is to br_target, not pc+4.
- req_pc=0xFFFFFFFC fetched: the next sequential request is 0x00000000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequential PC generation, one outstanding instruction-memory read,
// and a single-entry output buffer handed to decode over the valid/allow_in handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [32:0] br_data,
    input  logic        ID_allow_in,
    output logic        IF_to_ID_valid,
    output logic [63:0] to_ID_data,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StValid
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        cancel_q, cancel_d;

    logic        br_taken;
    logic [31:0] br_target;

    assign br_taken  = br_data[32];
    assign br_target = br_data[31:0];

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        cancel_d   = cancel_q;

        unique case (state_q)
            StReq: begin
                if (inst_sram_addr_ok) begin
                    state_d = StWait;
                    if (br_taken) begin
                        // Request already accepted: its data must be dropped on return.
                        cancel_d = 1'b1;
                        req_pc_d = br_target;
                    end else begin
                        out_pc_d = req_pc_q;
                        req_pc_d = req_pc_q + 32'd4;
                    end
                end else if (br_taken) begin
                    req_pc_d = br_target;
                end
            end
            StWait: begin
                if (inst_sram_data_ok) begin
                    if (cancel_q || br_taken) begin
                        cancel_d = 1'b0;
                        state_d  = StReq;
                        if (br_taken) begin
                            req_pc_d = br_target;
                        end
                    end else begin
                        out_inst_d = inst_sram_rdata;
                        state_d    = StValid;
                    end
                end else if (br_taken) begin
                    cancel_d = 1'b1;
                    req_pc_d = br_target;
                end
            end
            StValid: begin
                if (br_taken) begin
                    req_pc_d = br_target;
                    state_d  = StReq;
                end else if (ID_allow_in) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StReq;
            req_pc_q   <= RESET_PC;
            out_pc_q   <= 32'd0;
            out_inst_q <= 32'd0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            cancel_q   <= cancel_d;
        end
    end

    assign inst_sram_req  = (state_q == StReq) && !reset;
    assign inst_sram_addr = req_pc_q;
    assign IF_to_ID_valid = (state_q == StValid) && !br_taken;
    assign to_ID_data     = {out_pc_q, out_inst_q};

endmodule
